spi_input: RTL and testbench
============================

# spi_input

Serial-to-parallel SPI receiver that is the counterpart of `spi_output`. It samples `miso` on rising `sclk` edges while `cs_n` is low and assembles MSB-first frames of `NBYTES` bytes. Each completed frame is presented on `in_bytes` with a one-cycle `frame_valid` strobe. It sits between the external SPI device and the game logic, which consumes the parallel word.

## Interface
- `NBYTES`, default 5: bytes per frame; frame width `W = 8*NBYTES` (default 40). Legal range is 1..16.
- `sclk`  in  1  serial clock; the only clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cs_n`  in  1  active-low frame select, synchronous to `sclk`.
- `miso`  in  1  serial data, MSB of byte 0 first.
- `in_bytes`  out  W  last complete frame; byte 0 is in `[W-1:W-8]`.
- `frame_valid`  out  1  one-cycle pulse when `in_bytes` updates.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.
- `byte_data`  out  8  last completed byte (see Configuration).
- `byte_valid`  out  1  one-cycle pulse per completed byte (see Configuration).
- `bit_cnt`  out  clog2(W)  bits received in the current frame (debug).

## Operation
- States:
  - IDLE: `cs_n` high, counter at 0.
  - SHIFT: `cs_n` low, accumulating bits.
- Transitions:
  - IDLE→SHIFT on the first edge with `cs_n`=0. That edge already samples `miso` as bit 0.
  - SHIFT→IDLE on any edge with `cs_n`=1.
- In SHIFT, each edge performs `shreg <= {shreg[W-2:0], miso}` and `bit_cnt <= bit_cnt+1`.
- Frame complete: on the edge that samples the last bit (`bit_cnt`=W-1 before the edge):
  - `in_bytes <= {shreg[W-2:0], miso}`.
  - `frame_valid <= 1`.
  - `bit_cnt` wraps to 0.
  - The FSM stays in SHIFT, so back-to-back frames need no gap while `cs_n` stays low.
- Byte complete: on every edge where `bit_cnt[2:0]`=7 before the edge:
  - `byte_data <= {shreg[6:0], miso}`.
  - `byte_valid <= 1`.
- Abort: an edge with `cs_n`=1 while `bit_cnt`≠0 gives:
  - `frame_err <= 1`.
  - `bit_cnt <= 0`, and the shift register is cleared.
  - `in_bytes` keeps its previous value.
- `cs_n`=1 while `bit_cnt`=0 is a normal idle edge and raises no error.
- `frame_valid`, `frame_err` and `byte_valid` are 0 on every edge where their condition is not met.

## Timing
- Reset values: `in_bytes`=0, `frame_valid`=0, `frame_err`=0, `byte_data`=0, `byte_valid`=0, `bit_cnt`=0, shift register 0, FSM in IDLE.
- Reset mid-frame discards the partial frame immediately (asynchronous). No `frame_err` is raised.
- Latency: `in_bytes` and `frame_valid` are valid after the W-th sampling edge. They are registered, not combinational from `miso`.
- `frame_valid` is high for exactly one `sclk` period per frame. `in_bytes` is stable until the next frame completes.
- On the last bit of a frame, the byte strobe and `frame_valid` fire on the same edge.
- If `cs_n` rises on the edge immediately after the last bit, there is no error, because `bit_cnt` is already 0.

## Configuration
- `SPI_INPUT_BYTE_STRB_EN`:
  - When defined, the per-byte path (`byte_data`, `byte_valid` and their logic) is compiled in.
  - When undefined, `byte_data` is tied to 8'h00 and `byte_valid` to 0, and no byte logic is synthesised.
  - Frame behaviour is identical in both cases.

## Test plan
- Reset: assert `reset` for 1 ns with `sclk` idle → all outputs 0 and `bit_cnt`=0.
- Single frame: drive 40'h8B9BABCBEB MSB-first over 40 edges with `cs_n`=0 → after the 40th edge `in_bytes`=40'h8B9BABCBEB. `frame_valid` is high for one cycle and `frame_err` stays 0.
- Back-to-back: two frames, 40'h8B9BABCBEB then 40'h0123456789, sent with `cs_n` held low over 80 edges:
  - Two `frame_valid` pulses, 40 edges apart.
  - `in_bytes` finally equals 40'h0123456789.
- Abort: 17 bits, then `cs_n`=1 for one edge → `frame_err` pulses once, `in_bytes` keeps its prior value, `bit_cnt`=0.
- Reset mid-frame: assert `reset` after 20 bits, then send a full 40'hFFFFFFFFFF frame → `in_bytes`=40'hFFFFFFFFFF, and there is no `frame_err`.
- Byte strobe with `SPI_INPUT_BYTE_STRB_EN` defined, using the frame 40'h8B9BABCBEB:
  - `byte_valid` pulses on edges 8/16/24/32/40.
  - `byte_data` takes 8B, 9B, AB, CB, EB in that order.
  - Without the macro, `byte_valid` stays 0.

Source files
------------

// File: rtl/spi_input.sv
// SPI receiver: samples miso on rising sclk while cs_n is low and assembles MSB-first frames of NBYTES bytes.
// Optional per-byte strobe path is compiled in when SPI_INPUT_BYTE_STRB_EN is defined.
module spi_input #(
   parameter int NBYTES = 5
) (
   input  logic                            sclk,
   input  logic                            reset,
   input  logic                            cs_n,
   input  logic                            miso,
   output logic [8*NBYTES-1:0]             in_bytes,
   output logic                            frame_valid,
   output logic                            frame_err,
   output logic [7:0]                      byte_data,
   output logic                            byte_valid,
   output logic [$clog2(8*NBYTES)-1:0]     bit_cnt
);

   localparam int W  = 8 * NBYTES;
   localparam int CW = $clog2(W);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t          state, state_next;
   logic [W-1:0]    shreg, shreg_next;
   logic [CW-1:0]   cnt_next;
   logic            frame_done;
   logic            abort;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      shreg_next = shreg;
      cnt_next   = bit_cnt;
      frame_done = 1'b0;
      abort      = 1'b0;

      case (state)
         IDLE:    if (!cs_n) state_next = SHIFT;
         SHIFT:   if (cs_n)  state_next = IDLE;
         default: state_next = IDLE;
      endcase

      if (!cs_n) begin
         shreg_next = {shreg[W-2:0], miso};
         if (bit_cnt == CW'(W - 1)) begin
            frame_done = 1'b1;
            cnt_next   = '0;
         end else begin
            cnt_next = bit_cnt + CW'(1);
         end
      end else begin
         // A deselect right after the last bit finds the counter already at 0: no error.
         abort      = (state == SHIFT) && (bit_cnt != '0);
         shreg_next = '0;
         cnt_next   = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         in_bytes    <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state       <= state_next;
         shreg       <= shreg_next;
         bit_cnt     <= cnt_next;
         frame_valid <= frame_done;
         frame_err   <= abort;
         if (frame_done) in_bytes <= shreg_next;
      end
   end

`ifdef SPI_INPUT_BYTE_STRB_EN
   logic byte_done;

   assign byte_done = !cs_n && (bit_cnt[2:0] == 3'b111);

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         byte_data  <= 8'h00;
         byte_valid <= 1'b0;
      end else begin
         byte_valid <= byte_done;
         if (byte_done) byte_data <= {shreg[6:0], miso};
      end
   end
`else
   assign byte_data  = 8'h00;
   assign byte_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spi_input.sv
// Randomised scoreboard bench for spi_input; a bit-queue reference model predicts frames, bytes and aborts.
module tb_spi_input;

   localparam int NBYTES = 5;
   localparam int W      = 8 * NBYTES;
   localparam int CW     = $clog2(W);

   logic          sclk, reset, cs_n, miso;
   logic [W-1:0]  in_bytes;
   logic          frame_valid, frame_err, byte_valid;
   logic [7:0]    byte_data;
   logic [CW-1:0] bit_cnt;

   int checks = 0;
   int errors = 0;

   bit            bits[$];
   logic [W-1:0]  exp_frame[$];
   logic [W-1:0]  exp_err[$];
   logic [7:0]    exp_byte[$];
   logic [W-1:0]  last_frame = '0;

   spi_input #(.NBYTES(NBYTES)) dut (
      .sclk        (sclk),
      .reset       (reset),
      .cs_n        (cs_n),
      .miso        (miso),
      .in_bytes    (in_bytes),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .byte_data   (byte_data),
      .byte_valid  (byte_valid),
      .bit_cnt     (bit_cnt)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: bits of the current frame held in a queue, interpreted arithmetically.
   task automatic model_edge(input logic cs, input logic b);
      logic [W-1:0] f;
      logic [7:0]   v;
      if (!cs) begin
         bits.push_back(b);
         if (bits.size() % 8 == 0) begin
            v = '0;
            for (int k = 0; k < 8; k++) v = {v[6:0], bits[bits.size() - 8 + k]};
            exp_byte.push_back(v);
         end
         if (bits.size() == W) begin
            f = '0;
            for (int k = 0; k < W; k++) f = (f << 1) | W'(bits[k]);
            exp_frame.push_back(f);
            last_frame = f;
            bits.delete();
         end
      end else if (bits.size() != 0) begin
         exp_err.push_back(last_frame);
         bits.delete();
      end
   endtask

   task automatic send_bit(input logic cs, input logic b);
      @(negedge sclk);
      cs_n = cs;
      miso = b;
      model_edge(cs, b);
      @(posedge sclk);
      #1;
      check("bit_cnt", 64'(bit_cnt), 64'(bits.size()));
   endtask

   task automatic send_frame(input logic [W-1:0] val);
      for (int i = W - 1; i >= 0; i--) send_bit(1'b0, val[i]);
   endtask

   task automatic send_partial(input logic [W-1:0] val, input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0, val[W-1-i]);
   endtask

   task automatic reset_dut();
      @(negedge sclk);
      #1;
      reset = 1'b1;
      cs_n  = 1'b1;
      bits.delete();
      last_frame = '0;
      #1;
      check("rst_in_bytes", 64'(in_bytes), 64'd0);
      check("rst_bit_cnt", 64'(bit_cnt), 64'd0);
      check("rst_strobes", {61'd0, frame_valid, frame_err, byte_valid}, 64'd0);
      check("rst_byte_data", 64'(byte_data), 64'd0);
      reset = 1'b0;
   endtask

   // Monitor: pops the scoreboard whenever the DUT raises a strobe.
   always @(negedge sclk) begin
      if (!reset) begin
         if (frame_valid) begin
            if (exp_frame.size() == 0) check("unexpected_frame_valid", 64'd1, 64'd0);
            else check("in_bytes", 64'(in_bytes), 64'(exp_frame.pop_front()));
         end
         if (frame_err) begin
            if (exp_err.size() == 0) check("unexpected_frame_err", 64'd1, 64'd0);
            else check("in_bytes_after_abort", 64'(in_bytes), 64'(exp_err.pop_front()));
         end
`ifdef SPI_INPUT_BYTE_STRB_EN
         if (byte_valid) begin
            if (exp_byte.size() == 0) check("unexpected_byte_valid", 64'd1, 64'd0);
            else check("byte_data", 64'(byte_data), 64'(exp_byte.pop_front()));
         end
`else
         check("byte_valid_tied", {63'd0, byte_valid}, 64'd0);
`endif
      end
   end

   initial begin
      logic [W-1:0] r;
      reset = 1'b1;
      cs_n  = 1'b1;
      miso  = 1'b0;
      #1;
      check("init_in_bytes", 64'(in_bytes), 64'd0);
      check("init_bit_cnt", 64'(bit_cnt), 64'd0);
      check("init_strobes", {61'd0, frame_valid, frame_err, byte_valid}, 64'd0);
      check("init_byte_data", 64'(byte_data), 64'd0);
      #1;
      reset = 1'b0;

      send_bit(1'b1, 1'b0);
      send_frame(40'h8B9BABCBEB);
      send_bit(1'b1, 1'b0);
      send_frame(40'h8B9BABCBEB);
      send_frame(40'h0123456789);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);

      send_partial(40'hA5A5A5A5A5, 17);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);

      send_partial(40'h5A5A5A5A5A, 20);
      reset_dut();
      send_frame(40'hFFFFFFFFFF);
      send_bit(1'b1, 1'b0);

      for (int it = 0; it < 150; it++) begin
         r = {$urandom, $urandom};
         case ($urandom_range(0, 9))
            0, 1:    send_partial(r, $urandom_range(1, W - 1));
            2:       send_bit(1'b1, 1'($urandom));
            3: begin
               send_partial(r, $urandom_range(1, W - 1));
               if ($urandom_range(0, 3) == 0) reset_dut();
            end
            default: send_frame(r);
         endcase
         if ($urandom_range(0, 3) == 0) send_bit(1'b1, 1'($urandom));
      end

      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      check("frames_drained", 64'(exp_frame.size()), 64'd0);
      check("errors_drained", 64'(exp_err.size()), 64'd0);
`ifdef SPI_INPUT_BYTE_STRB_EN
      check("bytes_drained", 64'(exp_byte.size()), 64'd0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
